// File: rtl/airlock_sequencer_if.sv
// ----------------------------------------------------------------------------
// airlock_sequencer_if: request/grant and actuator bundle of the airlock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface airlock_sequencer_if;
  logic       arriveReq;
  logic       departReq;
  logic       arriveGrant;
  logic       departGrant;
  logic       innerOpen;
  logic       outerOpen;
  logic       pressurizeCmd;
  logic       evacuateCmd;
  logic       busy;
  logic       done;
  logic [1:0] occupancy;
  logic       full;
  logic       empty;
  logic [2:0] debugState;

  modport slave (
    input  arriveReq, departReq,
    output arriveGrant, departGrant, innerOpen, outerOpen, pressurizeCmd,
           evacuateCmd, busy, done, occupancy, full, empty, debugState
  );

  modport master (
    output arriveReq, departReq,
    input  arriveGrant, departGrant, innerOpen, outerOpen, pressurizeCmd,
           evacuateCmd, busy, done, occupancy, full, empty, debugState
  );
endinterface

`default_nettype wire

// File: rtl/airlock_sequencer.sv
// ----------------------------------------------------------------------------
// airlock_sequencer: round-robin arbiter and interlocked airlock phase sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module airlock_sequencer #(
  parameter int CAPACITY    = 3,
  parameter int PUMP_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  airlock_sequencer_if.slave  bus
);

  localparam int c_max_len = (PUMP_CYCLES > DOOR_CYCLES) ? PUMP_CYCLES : DOOR_CYCLES;
  localparam int c_cw      = $clog2(c_max_len + 1);

  localparam logic [c_cw-1:0] c_pump_last = c_cw'(PUMP_CYCLES - 1);
  localparam logic [c_cw-1:0] c_door_last = c_cw'(DOOR_CYCLES - 1);
  localparam logic [1:0]      c_capacity  = 2'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUMP_PRE = 3'd1,
    S_DOOR1    = 3'd2,
    S_PUMP_MID = 3'd3,
    S_DOOR2    = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;       // 0 = arrival, 1 = departure
  logic            press_q, press_d;   // chamber currently pressurized
  logic            last_q, last_d;     // direction served most recently
  logic [1:0]      occ_q, occ_d;

  logic arr_grant_q, arr_grant_d;
  logic dep_grant_q, dep_grant_d;
  logic inner_q, inner_d;
  logic outer_q, outer_d;
  logic pcmd_q, pcmd_d;
  logic ecmd_q, ecmd_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic full_w;
  logic empty_w;
  logic arr_elig_w;
  logic dep_elig_w;
  logic pick_dep_w;

  assign full_w     = (occ_q == c_capacity);
  assign empty_w    = (occ_q == 2'd0);
  assign arr_elig_w = bus.arriveReq && !full_w;
  assign dep_elig_w = bus.departReq && !empty_w;
  // On a tie the direction not served last time wins.
  assign pick_dep_w = dep_elig_w && (!arr_elig_w || !last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    dir_d       = dir_q;
    press_d     = press_q;
    last_d      = last_q;
    occ_d       = occ_q;
    arr_grant_d = 1'b0;
    dep_grant_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (arr_elig_w || dep_elig_w) begin
          dir_d       = pick_dep_w;
          arr_grant_d = !pick_dep_w;
          dep_grant_d = pick_dep_w;
          // Pre-pump only when the chamber is not already at the near-side pressure.
          state_d     = (pick_dep_w == press_q) ? S_DOOR1 : S_PUMP_PRE;
        end
      end
      S_PUMP_PRE: begin
        if (cnt_q == c_pump_last) begin
          state_d = S_DOOR1;
          cnt_d   = '0;
        end
      end
      S_DOOR1: begin
        if (cnt_q == c_door_last) begin
          state_d = S_PUMP_MID;
          cnt_d   = '0;
        end
      end
      S_PUMP_MID: begin
        if (cnt_q == c_pump_last) begin
          state_d = S_DOOR2;
          cnt_d   = '0;
        end
      end
      S_DOOR2: begin
        if (cnt_q == c_door_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        occ_d   = dir_q ? (occ_q - 2'd1) : (occ_q + 2'd1);
        press_d = !dir_q;
        last_d  = dir_q;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    inner_d = ((state_d == S_DOOR1) && dir_d)  || ((state_d == S_DOOR2) && !dir_d);
    outer_d = ((state_d == S_DOOR1) && !dir_d) || ((state_d == S_DOOR2) && dir_d);
    pcmd_d  = ((state_d == S_PUMP_PRE) && dir_d)  || ((state_d == S_PUMP_MID) && !dir_d);
    ecmd_d  = ((state_d == S_PUMP_PRE) && !dir_d) || ((state_d == S_PUMP_MID) && dir_d);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      press_q     <= 1'b1;
      last_q      <= 1'b1;
      occ_q       <= 2'd0;
      arr_grant_q <= 1'b0;
      dep_grant_q <= 1'b0;
      inner_q     <= 1'b0;
      outer_q     <= 1'b0;
      pcmd_q      <= 1'b0;
      ecmd_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      press_q     <= press_d;
      last_q      <= last_d;
      occ_q       <= occ_d;
      arr_grant_q <= arr_grant_d;
      dep_grant_q <= dep_grant_d;
      inner_q     <= inner_d;
      outer_q     <= outer_d;
      pcmd_q      <= pcmd_d;
      ecmd_q      <= ecmd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.arriveGrant   = arr_grant_q;
  assign bus.departGrant   = dep_grant_q;
  assign bus.innerOpen     = inner_q;
  assign bus.outerOpen     = outer_q;
  assign bus.pressurizeCmd = pcmd_q;
  assign bus.evacuateCmd   = ecmd_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.occupancy     = occ_q;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.debugState    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_airlock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_airlock_sequencer: randomized self-checking bench for airlock_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_airlock_sequencer;
  localparam int CAP = 3;
  localparam int PC  = 8;
  localparam int DC  = 4;

  // Trace entries are {busy, innerOpen, outerOpen, pressurizeCmd, evacuateCmd}.
  localparam logic [4:0] c_inner = 5'b11000;
  localparam logic [4:0] c_outer = 5'b10100;
  localparam logic [4:0] c_press = 5'b10010;
  localparam logic [4:0] c_evac  = 5'b10001;
  localparam logic [4:0] c_done  = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_occ;
  bit m_press;
  bit m_last;

  always #5 clk = ~clk;

  airlock_sequencer_if bus ();

  airlock_sequencer #(
    .CAPACITY   (CAP),
    .PUMP_CYCLES(PC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (chk_en) begin
      logic bad;
      bad = (bus.innerOpen && bus.outerOpen)
         || (bus.pressurizeCmd && bus.evacuateCmd)
         || ((bus.pressurizeCmd || bus.evacuateCmd) && (bus.innerOpen || bus.outerOpen))
         || (((bus.debugState == 3'd0) || (bus.debugState == 3'd5))
             && (bus.innerOpen || bus.outerOpen || bus.pressurizeCmd || bus.evacuateCmd))
         || (bus.arriveGrant && bus.departGrant);
      n_tests++;
      assert (!bad) else begin
        n_fail++;
        $display("FAIL interlock: got state %0d cmds %b%b%b%b grants %b%b, required no conflict",
                 bus.debugState, bus.innerOpen, bus.outerOpen, bus.pressurizeCmd,
                 bus.evacuateCmd, bus.arriveGrant, bus.departGrant);
      end
    end
  end

  function automatic void model_reset();
    m_occ   = 0;
    m_press = 1'b1;
    m_last  = 1'b1;
  endfunction

  function automatic int model_pick(input bit a, input bit d);
    bit ea = a && (m_occ < CAP);
    bit ed = d && (m_occ > 0);
    if (ea && ed) return m_last ? 0 : 1;
    if (ea) return 0;
    if (ed) return 1;
    return -1;
  endfunction

  task automatic model_trace(input bit dir, output logic [4:0] q[$]);
    q = {};
    if (!dir) begin
      if (m_press) repeat (PC) q.push_back(c_evac);
      repeat (DC) q.push_back(c_outer);
      repeat (PC) q.push_back(c_press);
      repeat (DC) q.push_back(c_inner);
    end else begin
      if (!m_press) repeat (PC) q.push_back(c_press);
      repeat (DC) q.push_back(c_inner);
      repeat (PC) q.push_back(c_evac);
      repeat (DC) q.push_back(c_outer);
    end
    q.push_back(c_done);
  endtask

  function automatic void model_commit(input bit dir);
    m_occ   = dir ? m_occ - 1 : m_occ + 1;
    m_press = !dir;
    m_last  = dir;
  endfunction

  function automatic logic [7:0] post_exp();
    logic [1:0] o = 2'(m_occ);
    return {(m_occ == CAP), (m_occ == 0), o, 1'b0, 3'd0};
  endfunction

  function automatic logic [7:0] post_obs();
    return {bus.full, bus.empty, bus.occupancy, bus.busy, bus.debugState};
  endfunction

  function automatic logic [4:0] cmd_obs();
    return {bus.busy, bus.innerOpen, bus.outerOpen, bus.pressurizeCmd, bus.evacuateCmd};
  endfunction

  function automatic int trace_diff(input logic [4:0] a[$], input logic [4:0] b[$]);
    int n = (a.size() > b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) begin
      if (i >= a.size() || i >= b.size()) return i;
      if (a[i] !== b[i]) return i;
    end
    return -1;
  endfunction

  // Waits a bounded number of cycles for a grant, then records the sequence up to done
  // and the first IDLE cycle after it.
  task automatic capture(input int limit, output int gdir, output int waited,
                         output logic [4:0] tr[$], output logic [7:0] post);
    gdir   = -1;
    waited = 0;
    tr     = {};
    while (waited < limit) begin
      @(posedge clk); #1;
      waited++;
      if (bus.arriveGrant || bus.departGrant) break;
    end
    if (!(bus.arriveGrant || bus.departGrant)) begin
      post = post_obs();
      return;
    end
    gdir = (bus.arriveGrant && bus.departGrant) ? 2 : (bus.departGrant ? 1 : 0);
    tr.push_back(cmd_obs());
    while (!bus.done && tr.size() < 100) begin
      @(posedge clk); #1;
      tr.push_back(cmd_obs());
    end
    @(posedge clk); #1;
    post = post_obs();
  endtask

  // Applies one request pattern, runs the model alongside and returns observed and expected.
  task automatic run_step(input bit a, input bit d, input bit keep, input int limit,
                          output int gdir, output int exp_dir, output int waited,
                          output int tdiff, output int tlen,
                          output logic [7:0] post, output logic [7:0] exp_post);
    logic [4:0] tr[$];
    logic [4:0] ex[$];
    ex      = {};
    exp_dir = model_pick(a, d);
    if (exp_dir >= 0) model_trace(exp_dir[0], ex);
    bus.arriveReq = a;
    bus.departReq = d;
    capture(limit, gdir, waited, tr, post);
    tdiff = trace_diff(tr, ex);
    tlen  = tr.size();
    if (exp_dir >= 0) model_commit(exp_dir[0]);
    exp_post = post_exp();
    if (!keep) begin
      bus.arriveReq = 1'b0;
      bus.departReq = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    bus.arriveReq = 1'b1;
    bus.departReq = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk_en = 1'b1;
      obs = {bus.arriveGrant, bus.departGrant, bus.innerOpen, bus.outerOpen,
             bus.pressurizeCmd, bus.evacuateCmd, bus.busy, bus.done, bus.full,
             bus.empty, bus.occupancy, bus.debugState};
      n_tests++;
      if (obs !== 15'b00_0000_0_0_0_1_00_000) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required %b", obs, 15'b00_0000_0_0_0_1_00_000);
      end
    end
    bus.arriveReq = 1'b0;
    bus.departReq = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_arrival();
    int gdir, exp_dir, waited, tdiff, tlen;
    logic [7:0] post, exp_post;
    run_step(1'b1, 1'b0, 1'b0, 10, gdir, exp_dir, waited, tdiff, tlen, post, exp_post);
    n_tests++;
    if (gdir !== 0) begin n_fail++; $display("FAIL arrival_dir: got %0d required 0", gdir); end
    n_tests++;
    if (waited !== 1) begin n_fail++; $display("FAIL arrival_latency: got %0d required 1", waited); end
    n_tests++;
    if (tdiff != -1) begin n_fail++; $display("FAIL arrival_trace: first diff at cycle %0d", tdiff); end
    n_tests++;
    if (tlen != 2*PC + 2*DC + 1) begin
      n_fail++; $display("FAIL arrival_length: got %0d required %0d", tlen, 2*PC + 2*DC + 1);
    end
    n_tests++;
    if (post !== exp_post) begin n_fail++; $display("FAIL arrival_post: got %b required %b", post, exp_post); end
  endtask

  task automatic test_departure();
    int gdir, exp_dir, waited, tdiff, tlen;
    logic [7:0] post, exp_post;
    run_step(1'b0, 1'b1, 1'b0, 10, gdir, exp_dir, waited, tdiff, tlen, post, exp_post);
    n_tests++;
    if (gdir !== 1) begin n_fail++; $display("FAIL departure_dir: got %0d required 1", gdir); end
    n_tests++;
    if (tdiff != -1) begin n_fail++; $display("FAIL departure_trace: first diff at cycle %0d", tdiff); end
    n_tests++;
    if (tlen != PC + 2*DC + 1) begin
      n_fail++; $display("FAIL departure_length: got %0d required %0d", tlen, PC + 2*DC + 1);
    end
    n_tests++;
    if (post !== 8'b01_00_0_000) begin n_fail++; $display("FAIL departure_post: got %b required %b", post, 8'b01_00_0_000); end
  endtask

  task automatic test_back_to_back_tie();
    bit a_t[8]  = '{1, 1, 0, 1, 1, 1, 1, 0};
    bit d_t[8]  = '{0, 0, 1, 1, 1, 1, 1, 0};
    int tie_exp[4] = '{0, 1, 0, 1};
    int gdir, exp_dir, waited, tdiff, tlen;
    logic [7:0] post, exp_post;
    for (int i = 0; i < 7; i++) begin
      run_step(a_t[i], d_t[i], (i >= 3), 10, gdir, exp_dir, waited, tdiff, tlen, post, exp_post);
      n_tests++;
      if (gdir !== exp_dir) begin n_fail++; $display("FAIL tie_dir[%0d]: got %0d required %0d", i, gdir, exp_dir); end
      if (i >= 3) begin
        n_tests++;
        if (gdir !== tie_exp[i-3]) begin
          n_fail++; $display("FAIL tie_alternate[%0d]: got %0d required %0d", i, gdir, tie_exp[i-3]);
        end
      end
      n_tests++;
      if (waited !== 1) begin n_fail++; $display("FAIL tie_gap[%0d]: got %0d required 1", i, waited); end
      n_tests++;
      if (tdiff != -1) begin n_fail++; $display("FAIL tie_trace[%0d]: first diff at cycle %0d", i, tdiff); end
      n_tests++;
      if (post !== exp_post) begin n_fail++; $display("FAIL tie_post[%0d]: got %b required %b", i, post, exp_post); end
    end
    bus.arriveReq = a_t[7];
    bus.departReq = d_t[7];
  endtask

  task automatic test_full_empty();
    bit a_t[7]   = '{1, 1, 1, 1, 0, 0, 0};
    bit d_t[7]   = '{0, 0, 0, 1, 1, 1, 1};
    int lim_t[7] = '{10, 10, 40, 10, 10, 10, 40};
    int gdir, exp_dir, waited, tdiff, tlen;
    logic [7:0] post, exp_post;
    for (int i = 0; i < 7; i++) begin
      run_step(a_t[i], d_t[i], 1'b0, lim_t[i], gdir, exp_dir, waited, tdiff, tlen, post, exp_post);
      n_tests++;
      if (gdir !== exp_dir) begin n_fail++; $display("FAIL fullempty_dir[%0d]: got %0d required %0d", i, gdir, exp_dir); end
      if (exp_dir >= 0) begin
        n_tests++;
        if (tdiff != -1) begin n_fail++; $display("FAIL fullempty_trace[%0d]: first diff at cycle %0d", i, tdiff); end
      end
      n_tests++;
      if (post !== exp_post) begin n_fail++; $display("FAIL fullempty_post[%0d]: got %b required %b", i, post, exp_post); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [14:0] obs;
    bus.arriveReq = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.arriveGrant && n < 10);
    bus.arriveReq = 1'b0;
    n = 0;
    while (bus.debugState != 3'd3 && n < 60) begin @(posedge clk); #1; n++; end
    n_tests++;
    if (bus.debugState !== 3'd3) begin
      n_fail++; $display("FAIL midreset_reach: got state %0d required 3", bus.debugState);
    end
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs = {bus.arriveGrant, bus.departGrant, bus.innerOpen, bus.outerOpen,
           bus.pressurizeCmd, bus.evacuateCmd, bus.busy, bus.done, bus.full,
           bus.empty, bus.occupancy, bus.debugState};
    n_tests++;
    if (obs !== 15'b00_0000_0_0_0_1_00_000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b required %b", obs, 15'b00_0000_0_0_0_1_00_000);
    end
    model_reset();
  endtask

  task automatic test_random();
    int gdir, exp_dir, waited, tdiff, tlen;
    logic [7:0] post, exp_post;
    bit a, d;
    for (int i = 0; i < 40; i++) begin
      a = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      run_step(a, d, 1'b0, 6, gdir, exp_dir, waited, tdiff, tlen, post, exp_post);
      n_tests++;
      if (gdir !== exp_dir) begin n_fail++; $display("FAIL random_dir[%0d]: got %0d required %0d", i, gdir, exp_dir); end
      n_tests++;
      if (tdiff != -1) begin n_fail++; $display("FAIL random_trace[%0d]: first diff at cycle %0d", i, tdiff); end
      n_tests++;
      if (post !== exp_post) begin n_fail++; $display("FAIL random_post[%0d]: got %b required %b", i, post, exp_post); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    bus.arriveReq = 1'b0;
    bus.departReq = 1'b0;
    model_reset();
    test_reset();
    test_arrival();
    test_departure();
    test_back_to_back_tie();
    test_full_empty();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
